// File: rtl/i2c_result_buf_pkg.sv
// Shared encodings for the I2C per-domain result buffer: domain codes,
// round-sequence states and default sizing.
package i2c_result_buf_pkg;

    localparam logic DOM_D1 = 1'b0;
    localparam logic DOM_D2 = 1'b1;

    localparam logic [0:0] EXP_D1 = 1'b0;
    localparam logic [0:0] EXP_D2 = 1'b1;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    // One beat as presented by the world controller.
    typedef struct packed {
        logic       valid;
        logic       domain;
        logic [7:0] data;
        logic       done;
    } in_beat_t;

endpackage

// File: rtl/i2c_dom_fifo.sv
// Single-domain synchronous FIFO with a registered read port that returns zero
// on any cycle without a pop. Storage scrubbing: I2C_RESULT_BUF_SCRUB_EN.
module i2c_dom_fifo
    import i2c_result_buf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] q,
    output logic       full,
    output logic       empty,
    output logic       dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [7:0]  q_reg;
    logic        push_ok;
    logic        pop_ok;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign rd_idx = rd_ptr_reg[AW-1:0];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dropped = push & full & ~pop_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            q_reg      <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                q_reg      <= mem[rd_idx];
            end else begin
                q_reg      <= '0;
            end
        end
    end

`ifdef I2C_RESULT_BUF_SCRUB_EN
    // Scrub first so a simultaneous push into the same slot (full case) wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop_ok) begin
                mem[rd_idx] <= '0;
            end
            if (push_ok) begin
                mem[wr_idx] <= wdata;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= wdata;
        end
    end
`endif

    assign q = q_reg;

endmodule

// File: rtl/i2c_result_buf.sv
// Sorts world-controller read bytes into per-domain FIFOs, checks the D1-then-D2
// round order and serves a domain-isolated read port. Option: I2C_RESULT_BUF_SCRUB_EN.
module i2c_result_buf
    import i2c_result_buf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_domain,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_done,
    input  logic             rd_req,
    input  logic             rd_domain,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic [1:0]       empty,
    output logic [1:0]       full,
    output logic [1:0]       ovf,
    output logic             seq_err,
    output logic [CNT_W-1:0] round_cnt,
    input  logic             clr
);

    in_beat_t beat;
    assign beat = '{valid: in_valid, domain: in_domain, data: in_data, done: in_done};

    logic [0:0]       state_reg, state_next;
    logic             d2_seen_reg, d2_seen_next;
    logic             accept;
    logic             seq_set;
    logic             round_inc;

    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       dropped;
    logic [1:0][7:0]  q;

    logic             rd_valid_reg;
    logic             rd_sel_reg;
    logic [1:0]       ovf_reg;
    logic             seq_err_reg;
    logic [CNT_W-1:0] round_cnt_reg;

    // Round sequencing: D1 opens a round, D2 (with or followed by done) closes it.
    always_comb begin
        state_next   = state_reg;
        d2_seen_next = d2_seen_reg;
        accept       = 1'b0;
        seq_set      = 1'b0;
        round_inc    = 1'b0;
        case (state_reg)
            EXP_D1: begin
                if (beat.done) begin
                    seq_set = 1'b1;
                end
                if (beat.valid) begin
                    if (beat.domain == DOM_D1) begin
                        accept       = 1'b1;
                        state_next   = EXP_D2;
                        d2_seen_next = 1'b0;
                    end else begin
                        seq_set = 1'b1;
                    end
                end
            end
            default: begin
                if (beat.valid && beat.domain == DOM_D1) begin
                    // A repeated D1 sample restarts the round but is not stored.
                    seq_set      = 1'b1;
                    d2_seen_next = 1'b0;
                end else if (beat.valid) begin
                    accept = 1'b1;
                    if (beat.done) begin
                        round_inc    = 1'b1;
                        state_next   = EXP_D1;
                        d2_seen_next = 1'b0;
                    end else begin
                        d2_seen_next = 1'b1;
                    end
                end else if (beat.done) begin
                    state_next   = EXP_D1;
                    d2_seen_next = 1'b0;
                    if (d2_seen_reg) begin
                        round_inc = 1'b1;
                    end else begin
                        seq_set = 1'b1;
                    end
                end
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dom
            assign push[gi] = accept & (beat.domain == 1'(gi));
            assign pop[gi]  = rd_req & (rd_domain == 1'(gi)) & ~empty[gi];

            i2c_dom_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .push    (push[gi]),
                .wdata   (beat.data),
                .pop     (pop[gi]),
                .q       (q[gi]),
                .full    (full[gi]),
                .empty   (empty[gi]),
                .dropped (dropped[gi])
            );
        end
    endgenerate

    // Clear is applied before the set terms so a same-cycle set survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EXP_D1;
            d2_seen_reg   <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_sel_reg    <= DOM_D1;
            ovf_reg       <= '0;
            seq_err_reg   <= 1'b0;
            round_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            d2_seen_reg   <= d2_seen_next;
            rd_valid_reg  <= |pop;
            rd_sel_reg    <= rd_domain;
            ovf_reg       <= (clr ? 2'b00 : ovf_reg) | dropped;
            seq_err_reg   <= (clr ? 1'b0 : seq_err_reg) | seq_set;
            round_cnt_reg <= (clr ? '0 : round_cnt_reg) + CNT_W'(round_inc);
        end
    end

    // Only the FIFO named by the registered rd_domain can reach the output.
    assign rd_data   = rd_valid_reg ? ((rd_sel_reg == DOM_D2) ? q[1] : q[0]) : 8'h00;
    assign rd_valid  = rd_valid_reg;
    assign ovf       = ovf_reg;
    assign seq_err   = seq_err_reg;
    assign round_cnt = round_cnt_reg;

endmodule

// File: tb/tb_i2c_result_buf.sv
// Self-checking bench for i2c_result_buf: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_i2c_result_buf;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_domain = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_done = 1'b0;
    logic             rd_req = 1'b0;
    logic             rd_domain = 1'b0;
    logic             clr = 1'b0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [1:0]       empty;
    logic [1:0]       full;
    logic [1:0]       ovf;
    logic             seq_err;
    logic [CNT_W-1:0] round_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    logic       m_expect_d2;
    logic       m_got_d2;
    logic [1:0] m_ovf;
    logic       m_seq;
    int         m_rc;
    logic       m_rv;
    logic [7:0] m_rd;

    always #5 clk = ~clk;

    i2c_result_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_domain (in_domain),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_done   (in_done),
        .rd_req    (rd_req),
        .rd_domain (rd_domain),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .seq_err   (seq_err),
        .round_cnt (round_cnt),
        .clr       (clr)
    );

    task automatic drive(input logic v, input logic dom, input logic [7:0] d, input logic done,
                         input logic req, input logic rdom, input logic c);
        in_valid = v; in_domain = dom; in_data = d; in_done = done;
        rd_req = req; rd_domain = rdom; clr = c;
        @(posedge clk); #1;
        in_valid = 1'b0; in_done = 1'b0; rd_req = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mq0.delete(); mq1.delete();
        m_expect_d2 = 1'b0; m_got_d2 = 1'b0; m_ovf = 2'b00; m_seq = 1'b0; m_rc = 0;
    endtask

    // Predicts outputs after the next edge from the rules: pop first, then the
    // round-order rules decide whether the byte is stored.
    task automatic model_step(input logic v, input logic dom, input logic [7:0] d, input logic done,
                              input logic req, input logic rdom, input logic c);
        logic store;
        store = 1'b0;
        m_rv = 1'b0; m_rd = 8'h00;
        if (req && rdom == 1'b0 && mq0.size() > 0) begin m_rv = 1'b1; m_rd = mq0.pop_front(); end
        if (req && rdom == 1'b1 && mq1.size() > 0) begin m_rv = 1'b1; m_rd = mq1.pop_front(); end
        if (c) begin m_ovf = 2'b00; m_seq = 1'b0; m_rc = 0; end
        if (!m_expect_d2) begin
            if (done) m_seq = 1'b1;
            if (v && !dom) begin store = 1'b1; m_expect_d2 = 1'b1; m_got_d2 = 1'b0; end
            else if (v) m_seq = 1'b1;
        end else begin
            if (v && !dom) begin m_seq = 1'b1; m_got_d2 = 1'b0; end
            else if (v) begin
                store = 1'b1;
                if (done) begin m_rc = (m_rc + 1) % 256; m_expect_d2 = 1'b0; end
                else m_got_d2 = 1'b1;
            end else if (done) begin
                if (m_got_d2) m_rc = (m_rc + 1) % 256;
                else m_seq = 1'b1;
                m_expect_d2 = 1'b0;
            end
        end
        if (store && !dom) begin
            if (mq0.size() < DEPTH) mq0.push_back(d); else m_ovf[0] = 1'b1;
        end
        if (store && dom) begin
            if (mq1.size() < DEPTH) mq1.push_back(d); else m_ovf[1] = 1'b1;
        end
    endtask

    task automatic test_reset();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0h want 0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %0h want 00", rd_data); end
        checks++; if (empty !== 2'b11) begin errors++; $display("FAIL reset_empty got %b want 11", empty); end
        checks++; if (full !== 2'b00) begin errors++; $display("FAIL reset_full got %b want 00", full); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b want 00", ovf); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err got %0h want 0", seq_err); end
        checks++; if (round_cnt !== 8'd0) begin errors++; $display("FAIL reset_round_cnt got %0d want 0", round_cnt); end
        $display("reset: empty=%b round_cnt=%0d", empty, round_cnt);
    endtask

    task automatic test_round();
        drive(1, 0, 8'h12, 0, 0, 0, 0);
        drive(1, 1, 8'h90, 1, 0, 0, 0);
        checks++; if (empty !== 2'b00) begin errors++; $display("FAIL round_empty got %b want 00", empty); end
        checks++; if (round_cnt !== 8'd1) begin errors++; $display("FAIL round_cnt got %0d want 1", round_cnt); end
        drive(0, 0, 0, 0, 1, 1, 0);
        $display("round: pop d2 valid=%0b data=%h", rd_valid, rd_data);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h90) begin errors++; $display("FAIL round_pop_d2 got %0b/%h want 1/90", rd_valid, rd_data); end
        drive(0, 0, 0, 0, 1, 1, 0);
        $display("isolation: pop empty d2 valid=%0b data=%h", rd_valid, rd_data);
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL iso_pop_d2 got %0b/%h want 0/00", rd_valid, rd_data); end
        checks++; if (empty !== 2'b10) begin errors++; $display("FAIL iso_empty got %b want 10", empty); end
        drive(0, 0, 0, 0, 1, 0, 0);
        $display("round: pop d1 valid=%0b data=%h", rd_valid, rd_data);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h12) begin errors++; $display("FAIL round_pop_d1 got %0b/%h want 1/12", rd_valid, rd_data); end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL idle_rd got %0b/%h want 0/00", rd_valid, rd_data); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d1 [4];
        exp_d1[0] = 8'h22; exp_d1[1] = 8'h23; exp_d1[2] = 8'h24; exp_d1[3] = 8'h26;
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 8'h21 + 8'(k), 0, 0, 0, 0);
            drive(1, 1, 8'h31 + 8'(k), 1, 0, 0, 0);
            drive(0, 0, 0, 0, 1, 1, 0);
            $display("overflow round %0d: d2 pop %h ovf=%b", k, rd_data, ovf);
            checks++; if (rd_data !== 8'h31 + 8'(k)) begin errors++; $display("FAIL ovf_d2_pop%0d got %h want %h", k, rd_data, 8'h31 + 8'(k)); end
        end
        checks++; if (ovf !== 2'b01) begin errors++; $display("FAIL ovf_flag got %b want 01", ovf); end
        checks++; if (full !== 2'b01) begin errors++; $display("FAIL ovf_full got %b want 01", full); end
        checks++; if (round_cnt !== 8'd6) begin errors++; $display("FAIL ovf_round_cnt got %0d want 6", round_cnt); end
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++; if (ovf !== 2'b00 || round_cnt !== 8'd0) begin errors++; $display("FAIL clr_ovf got %b/%0d want 00/0", ovf, round_cnt); end
        // Full FIFO: push and pop together must both succeed without overflow.
        drive(1, 0, 8'h26, 0, 1, 0, 0);
        $display("full push+pop: data=%h ovf=%b full=%b", rd_data, ovf, full);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h21) begin errors++; $display("FAIL fullpp_rd got %0b/%h want 1/21", rd_valid, rd_data); end
        checks++; if (ovf !== 2'b00 || full !== 2'b01) begin errors++; $display("FAIL fullpp_flags got %b/%b want 00/01", ovf, full); end
        drive(1, 1, 8'h36, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        checks++; if (rd_data !== 8'h36) begin errors++; $display("FAIL fullpp_d2 got %h want 36", rd_data); end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            $display("overflow drain %0d: valid=%0b data=%h", k, rd_valid, rd_data);
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d1[k]) begin errors++; $display("FAIL ovf_drain%0d got %0b/%h want 1/%h", k, rd_valid, rd_data, exp_d1[k]); end
        end
        checks++; if (empty !== 2'b11) begin errors++; $display("FAIL ovf_empty got %b want 11", empty); end
    endtask

    task automatic test_mid_reset();
        drive(1, 0, 8'h55, 0, 0, 0, 0);
        checks++; if (empty !== 2'b10) begin errors++; $display("FAIL mr_pre_empty got %b want 10", empty); end
        rst_n = 1'b0;
        #2;
        $display("mid reset: empty=%b round_cnt=%0d", empty, round_cnt);
        checks++; if (empty !== 2'b11 || round_cnt !== 8'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00)
            begin errors++; $display("FAIL mr_outputs got %b/%0d/%0b/%h want 11/0/0/00", empty, round_cnt, rd_valid, rd_data); end
        checks++; if (ovf !== 2'b00 || seq_err !== 1'b0) begin errors++; $display("FAIL mr_flags got %b/%0b want 00/0", ovf, seq_err); end
        rst_n = 1'b1;
        drive(1, 0, 8'h66, 0, 0, 0, 0);
        drive(1, 1, 8'h67, 1, 0, 0, 0);
        checks++; if (round_cnt !== 8'd1 || seq_err !== 1'b0 || empty !== 2'b00)
            begin errors++; $display("FAIL mr_round got %0d/%0b/%b want 1/0/00", round_cnt, seq_err, empty); end
        drive(0, 0, 0, 0, 1, 0, 0);
        checks++; if (rd_data !== 8'h66) begin errors++; $display("FAIL mr_pop_d1 got %h want 66", rd_data); end
        drive(0, 0, 0, 0, 1, 1, 0);
        checks++; if (rd_data !== 8'h67) begin errors++; $display("FAIL mr_pop_d2 got %h want 67", rd_data); end
    endtask

    task automatic test_seq_err();
        drive(1, 1, 8'h77, 0, 0, 0, 0);
        $display("seq: d2 in EXP_D1 seq_err=%0b empty=%b", seq_err, empty);
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_set got %0b want 1", seq_err); end
        checks++; if (empty !== 2'b11) begin errors++; $display("FAIL seq_nostore got %b want 11", empty); end
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++; if (seq_err !== 1'b0 || round_cnt !== 8'd0) begin errors++; $display("FAIL seq_clr got %0b/%0d want 0/0", seq_err, round_cnt); end
        drive(1, 0, 8'h11, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        $display("seq: done without d2 seq_err=%0b round_cnt=%0d", seq_err, round_cnt);
        checks++; if (seq_err !== 1'b1 || round_cnt !== 8'd0) begin errors++; $display("FAIL seq_nod2 got %0b/%0d want 1/0", seq_err, round_cnt); end
        drive(0, 0, 0, 0, 1, 0, 1);
        checks++; if (rd_data !== 8'h11 || seq_err !== 1'b0) begin errors++; $display("FAIL seq_drain got %h/%0b want 11/0", rd_data, seq_err); end
    endtask

`ifdef I2C_RESULT_BUF_SCRUB_EN
    task automatic test_scrub();
        do_reset();
        drive(1, 0, 8'hA5, 0, 0, 0, 0);
        checks++; if (u_dut.g_dom[0].u_fifo.mem[0] !== 8'hA5) begin errors++; $display("FAIL scrub_stored got %h want a5", u_dut.g_dom[0].u_fifo.mem[0]); end
        drive(1, 1, 8'h5A, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        $display("scrub: popped %h storage now %h", rd_data, u_dut.g_dom[0].u_fifo.mem[0]);
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL scrub_pop got %h want a5", rd_data); end
        checks++; if (u_dut.g_dom[0].u_fifo.mem[0] !== 8'h00) begin errors++; $display("FAIL scrub_cleared got %h want 00", u_dut.g_dom[0].u_fifo.mem[0]); end
    endtask
`endif

    task automatic test_random();
        logic v, dom, done, req, rdom, c;
        logic [7:0] d;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v    = ($urandom_range(0, 1) == 1);
            dom  = ($urandom_range(0, 2) != 0) ? m_expect_d2 : 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            if (v && dom) done = ($urandom_range(0, 1) == 1);
            else if (!v)  done = ($urandom_range(0, 9) == 0);
            else          done = 1'b0;
            req  = ($urandom_range(0, 2) == 0);
            rdom = 1'($urandom_range(0, 1));
            c    = ($urandom_range(0, 19) == 0);
            model_step(v, dom, d, done, req, rdom, c);
            drive(v, dom, d, done, req, rdom, c);
            if (m_rv) $display("random %0d: pop dom%0d data=%h want %h", n, rdom, rd_data, m_rd);
            checks++; if (rd_valid !== m_rv || rd_data !== m_rd) begin errors++; $display("FAIL rand_rd@%0d got %0b/%h want %0b/%h", n, rd_valid, rd_data, m_rv, m_rd); end
            checks++; if (empty !== {mq1.size() == 0, mq0.size() == 0}) begin errors++; $display("FAIL rand_empty@%0d got %b want %b", n, empty, {mq1.size() == 0, mq0.size() == 0}); end
            checks++; if (full !== {mq1.size() == DEPTH, mq0.size() == DEPTH}) begin errors++; $display("FAIL rand_full@%0d got %b want %b", n, full, {mq1.size() == DEPTH, mq0.size() == DEPTH}); end
            checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf@%0d got %b want %b", n, ovf, m_ovf); end
            checks++; if (seq_err !== m_seq) begin errors++; $display("FAIL rand_seq@%0d got %0b want %0b", n, seq_err, m_seq); end
            checks++; if (round_cnt !== 8'(m_rc)) begin errors++; $display("FAIL rand_rc@%0d got %0d want %0d", n, round_cnt, m_rc); end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_round();
        test_overflow();
        test_mid_reset();
        test_seq_err();
`ifdef I2C_RESULT_BUF_SCRUB_EN
        test_scrub();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_result_buf.md
Name: i2c_result_buf

Overview:
- Downstream consumer of the I2C world controller's per-domain read results (rd_data / valid / done, plus the current domain bit).
- Sorts each returned byte into a per-domain FIFO (D1 = domain 0, D2 = domain 1) and checks the D1-then-D2 round sequence.
- Serves a single read port that never returns one domain's data to a requester of the other domain.

Parameters:
- DEPTH, 4: entries per domain FIFO; power of two, 2..16.
- CNT_W, 8: width of the completed-round counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_domain  input  1  domain of the current transfer (0 = D1, 1 = D2).
- in_valid  input  1  one-cycle strobe; in_data is valid.
- in_data  input  8  read byte from the world controller.
- in_done  input  1  one-cycle strobe; round complete (coincides with the D2 in_valid).
- rd_req  input  1  pop request.
- rd_domain  input  1  domain being read.
- rd_data  output  8  popped byte.
- rd_valid  output  1  rd_data is valid.
- empty  output  2  per-domain empty flags, bit0 = D1.
- full  output  2  per-domain full flags.
- ovf  output  2  sticky per-domain overflow.
- seq_err  output  1  sticky sequence error.
- round_cnt  output  CNT_W  completed rounds, wraps.
- clr  input  1  synchronous clear of ovf, seq_err and round_cnt.

Behaviour:
Reset (rst_n low, asynchronous):
- Both FIFOs empty, pointers 0.
- rd_data = 0, rd_valid = 0, ovf = 0, seq_err = 0, round_cnt = 0.
- Sequence FSM in EXP_D1.

Write side:
- On in_valid, in_data is pushed into the FIFO selected by in_domain, subject to the FSM check.
- FIFO full: byte dropped, ovf[in_domain] set; the FSM still advances.

Sequence FSM:
- EXP_D1:
  - in_valid & in_domain = 0: push, go to EXP_D2.
  - in_valid & in_domain = 1: drop, set seq_err, stay.
  - in_done: set seq_err, stay.
- EXP_D2:
  - in_valid & in_domain = 1 & in_done: push, round_cnt++, go to EXP_D1.
  - in_valid & in_domain = 1 without in_done: push, stay in EXP_D2 awaiting in_done.
  - in_done without in_valid while in EXP_D2 after a D2 push: round_cnt++, go to EXP_D1.
  - in_done without in_valid, no D2 push seen: set seq_err, go to EXP_D1.
  - in_valid & in_domain = 0: drop, set seq_err, go to EXP_D2 (treated as a restarted D1 sample; not pushed).

Read side (1-cycle latency):
- rd_req & !empty[rd_domain]: next cycle rd_valid = 1 and rd_data = head of FIFO[rd_domain]; pointer advances.
- rd_req on an empty domain: next cycle rd_valid = 0, rd_data = 0.
- Whenever rd_valid = 0, rd_data is forced to 0; no stale data is ever held on the output.
- The selected FIFO is addressed by rd_domain only. No path exists from FIFO[d] to rd_data unless rd_domain = d.

Simultaneous events:
- Push and pop on the same FIFO in the same cycle are both honoured.
- When full, push + pop in the same cycle succeeds and does not set ovf.

Clear and mid-operation reset:
- clr zeroes ovf, seq_err and round_cnt. FIFO contents and FSM state are untouched.
- If clr and a set event occur in the same cycle, the set wins.
- Reset mid-round discards all FIFO contents; the FSM restarts in EXP_D1.

Arithmetic:
- Pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare.
- round_cnt wraps modulo 2^CNT_W.

Optional Feature:
- Macro: I2C_RESULT_BUF_SCRUB_EN.
- Defined: a popped entry is overwritten with 8'h00 on the same edge the pointer advances, and reset zeroes the full storage arrays. Stale domain data never remains in storage.
- Undefined: storage is not cleared and has no reset; only the pointers reset.

Decomposition:
- Shared package:
  - domain encodings DOM_D1 = 1'b0, DOM_D2 = 1'b1;
  - FSM state constants EXP_D1 / EXP_D2;
  - default DEPTH.
- Natural sub-module: i2c_dom_fifo, a single-domain synchronous FIFO with push/pop/full/empty and the scrub hook. It is instantiated twice; the top holds the FSM, flags and read mux.

Test Plan:
- Round D1 = 8'h12 then D2 = 8'h90 with in_done → empty = 2'b00, round_cnt = 1; rd_domain = 1 pop returns 8'h90 with rd_valid the next cycle; rd_domain = 0 pop returns 8'h12.
- Pop of D2 while only D1 holds data → rd_valid = 0, rd_data = 8'h00; D1 still holds 8'h12.
- DEPTH+1 = 5 D1 pushes without popping (each D1 push followed by a D2 push with in_done) → ovf = 2'b01, fifth D1 byte dropped, pops return the first four in order.
- D2 byte arriving in EXP_D1 → seq_err = 1, byte not stored, empty[1] = 1; clr → seq_err = 0.
- rst_n pulsed low mid-round after the D1 push → all outputs 0, empty = 2'b11, FSM in EXP_D1; a subsequent full round counts round_cnt = 1.
- Scrub enabled: push 8'hA5, pop, then inspect storage → entry reads 8'h00.
